// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one magnitude bit per clock.
// Converts the low IN_W bits of |value_in| into DIGITS packed BCD digits, with sign and overflow flags.
module bcd_seq_ctrl #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           value_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    mag_q, mag_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_w_q, neg_w_d;
  logic               ovf_w_q, ovf_w_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        mag_full;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shifted;

  // Datapath for one shift step: correct every digit first, then shift in the next magnitude bit.
  always_comb begin
    mag_full = value_in[31] ? (~value_in + 32'd1) : value_in;
    acc_adj  = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    acc_shifted = {acc_adj[ACC_W-2:0], mag_q[cnt_q]};
  end

  always_comb begin
    // NOTE: every *_d gets a default of its *_q first, so no path through the case infers a latch.
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_w_d = neg_w_q;
    ovf_w_d = ovf_w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          mag_d   = mag_full[IN_W-1:0];
          neg_w_d = value_in[31];
          ovf_w_d = |mag_full[31:IN_W];
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_W - 1);
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = acc_shifted;
          neg_d   = neg_w_q;
          ovf_d   = ovf_w_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_w_q <= 1'b0;
      ovf_w_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_w_q <= neg_w_d;
      ovf_w_q <= ovf_w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule
